// File: rtl/mult_calc_pkg.sv
// Shared state encoding and sizing defaults for the signed-multiply calculator path.
package mult_calc_pkg;

  localparam int DEF_IN_W       = 8;
  localparam int DEF_BCD_DIGITS = 5;
  localparam int DEF_WIN_DIGITS = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MULT    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_CONV    = 3'd3,
    ST_SHOW    = 3'd4
  } state_e;

  function automatic int win_pos_max(input int bcd_digits, input int win_digits);
    return bcd_digits - win_digits;
  endfunction

  function automatic int win_pos_width(input int bcd_digits, input int win_digits);
    int m;
    m = win_pos_max(bcd_digits, win_digits);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bcd_seq_conv.sv
// Iterative double-dabble: one binary bit per cycle, MSB first, BIN_W cycles per load.
module bcd_seq_conv
  import mult_calc_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = DEF_BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] sh_q, sh_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    adj_s;

  function automatic logic [BW-1:0] dd_adjust(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      else                      r[4*i +: 4] = v[4*i +: 4];
    end
    return r;
  endfunction

  assign adj_s = dd_adjust(bcd_q);

  // Load restarts the conversion; otherwise shift while bits remain.
  always_comb begin
    sh_d  = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (load) begin
      sh_d  = bin;
      bcd_d = '0;
      cnt_d = CW'(BIN_W);
    end else if (cnt_q != '0) begin
      bcd_d = (adj_s << 1) | BW'(sh_q[BIN_W-1]);
      sh_d  = sh_q << 1;
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  // done marks the cycle whose closing edge performs the final shift.
  assign done = (cnt_q == CW'(1)) && !load;
  assign bcd  = bcd_q;

endmodule

// File: rtl/mult_display_sequencer.sv
// Sequencer: operands to sign/magnitude, multiplier handshake, BCD conversion, scrollable display window.
module mult_display_sequencer
  import mult_calc_pkg::*;
#(
  parameter int IN_W       = DEF_IN_W,
  parameter int BCD_DIGITS = DEF_BCD_DIGITS,
  parameter int WIN_DIGITS = DEF_WIN_DIGITS,
  localparam int POS_W     = win_pos_width(BCD_DIGITS, WIN_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic [IN_W-1:0]         a,
  input  logic [IN_W-1:0]         b,
  input  logic                    scroll_left,
  input  logic                    scroll_right,
  output logic                    mult_start,
  output logic [IN_W-1:0]         mult_multiplier,
  output logic [IN_W-1:0]         mult_multiplicand,
  input  logic [2*IN_W-1:0]       mult_product,
  input  logic                    mult_done,
  output logic                    busy,
  output logic                    valid,
  output logic                    negative,
  output logic [POS_W-1:0]        win_pos,
  output logic [4*WIN_DIGITS-1:0] window
);

  localparam int PW      = 2 * IN_W;
  localparam int WW      = 4 * WIN_DIGITS;
  localparam int POS_MAX = win_pos_max(BCD_DIGITS, WIN_DIGITS);

  state_e                state_q, state_d;
  logic [IN_W-1:0]       mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic                  sign_q, sign_d;
  logic [PW-1:0]         prod_q, prod_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic                  accept_go_s, rel_exit_s, conv_done_s;
  logic [4*BCD_DIGITS-1:0] conv_bcd_s;

  // Two's complement magnitude; the most negative value maps to its unsigned magnitude.
  function automatic logic [IN_W-1:0] magnitude(input logic [IN_W-1:0] v);
    return v[IN_W-1] ? (~v + IN_W'(1)) : v;
  endfunction

  assign accept_go_s = go && ((state_q == ST_IDLE) || (state_q == ST_SHOW));
  assign rel_exit_s  = (state_q == ST_RELEASE) && !mult_done;

  // A load on go clears the BCD register; the load on RELEASE exit starts the real conversion.
  bcd_seq_conv #(.BIN_W(PW), .DIGITS(BCD_DIGITS)) u_conv (
    .clk  (clk),
    .rst  (rst),
    .load (accept_go_s || rel_exit_s),
    .bin  (prod_q),
    .bcd  (conv_bcd_s),
    .done (conv_done_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      sign_q  <= 1'b0;
      prod_q  <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      sign_q  <= sign_d;
      prod_q  <= prod_d;
      pos_q   <= pos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_SHOW: if (go) state_d = ST_MULT; else state_d = state_q;
      ST_MULT:          if (mult_done) state_d = ST_RELEASE; else state_d = state_q;
      ST_RELEASE:       if (!mult_done) state_d = ST_CONV; else state_d = state_q;
      ST_CONV:          if (conv_done_s) state_d = ST_SHOW; else state_d = state_q;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Operand capture, product latch and window position.
  always_comb begin
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    sign_d  = sign_q;
    prod_d  = prod_q;
    pos_d   = pos_q;
    if (accept_go_s) begin
      mag_a_d = magnitude(a);
      mag_b_d = magnitude(b);
      sign_d  = a[IN_W-1] ^ b[IN_W-1];
      pos_d   = '0;
    end else if ((state_q == ST_MULT) && mult_done) begin
      prod_d = mult_product;
    end else if (state_q == ST_SHOW) begin
      if (scroll_left && !scroll_right && (pos_q < POS_W'(POS_MAX)))
        pos_d = pos_q + POS_W'(1);
      else if (scroll_right && !scroll_left && (pos_q != '0))
        pos_d = pos_q - POS_W'(1);
      else
        pos_d = pos_q;
    end else begin
      pos_d = pos_q;
    end
  end

  always_comb begin
    mult_start = 1'b0;
    busy       = 1'b0;
    valid      = 1'b0;
    case (state_q)
      ST_MULT:    begin mult_start = 1'b1; busy = 1'b1; end
      ST_RELEASE: busy  = 1'b1;
      ST_CONV:    busy  = 1'b1;
      ST_SHOW:    valid = 1'b1;
      default:    valid = 1'b0;
    endcase
  end

  assign mult_multiplicand = mag_a_q;
  assign mult_multiplier   = mag_b_q;
  assign win_pos           = pos_q;
  assign negative          = valid && sign_q && (prod_q != '0);
  assign window            = valid ? conv_bcd_s[int'(pos_q)*4 +: WW] : '0;

endmodule

// File: tb/tb_mult_display_sequencer.sv
// Self-checking bench: 5-cycle multiplier model, arithmetic reference for window/sign, random and directed scenarios.
module tb_mult_display_sequencer;

  logic        clk = 1'b0;
  logic        rst, go, scroll_left, scroll_right;
  logic [7:0]  a, b;
  logic        mult_start, busy, valid, negative;
  logic [7:0]  mult_multiplier, mult_multiplicand;
  logic [15:0] mult_product;
  logic        mult_done;
  logic [0:0]  win_pos;
  logic [15:0] window;

  int n_cmp = 0;
  int n_mis = 0;
  int start_rises = 0;
  logic start_prev = 1'b0;
  logic [2:0] mcnt;

  always #5 clk = ~clk;

  mult_display_sequencer dut (
    .clk(clk), .rst(rst), .go(go), .a(a), .b(b),
    .scroll_left(scroll_left), .scroll_right(scroll_right),
    .mult_start(mult_start), .mult_multiplier(mult_multiplier),
    .mult_multiplicand(mult_multiplicand), .mult_product(mult_product),
    .mult_done(mult_done), .busy(busy), .valid(valid), .negative(negative),
    .win_pos(win_pos), .window(window)
  );

  // Multiplier model: done 5 cycles after start, held until start drops.
  always @(posedge clk) begin
    if (rst || !mult_start) begin
      mult_done <= 1'b0;
      mcnt      <= 3'd0;
    end else if (!mult_done) begin
      if (mcnt == 3'd4) begin
        mult_done    <= 1'b1;
        mult_product <= 16'(mult_multiplicand) * 16'(mult_multiplier);
      end else begin
        mcnt <= mcnt + 3'd1;
      end
    end
  end

  always @(posedge clk) begin
    start_prev <= mult_start;
    if (mult_start && !start_prev) start_rises <= start_rises + 1;
  end

  // Reference: decimal digits of |a|*|b| by plain division.
  function automatic int ref_prod(input logic [7:0] x, input logic [7:0] y);
    int sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    if (sx < 0) sx = -sx;
    if (sy < 0) sy = -sy;
    return sx * sy;
  endfunction

  function automatic logic [15:0] ref_window(input int p, input int pos);
    logic [15:0] w;
    int q;
    q = p;
    w = 16'h0000;
    for (int k = 0; k < pos; k++) q = q / 10;
    for (int i = 0; i < 4; i++) begin
      w[i*4 +: 4] = 4'(q % 10);
      q = q / 10;
    end
    return w;
  endfunction

  function automatic logic ref_neg(input logic [7:0] x, input logic [7:0] y);
    return (ref_prod(x, y) != 0) && (x[7] ^ y[7]);
  endfunction

  task automatic do_go(input logic [7:0] ia, input logic [7:0] ib);
    @(negedge clk);
    a = ia; b = ib; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (valid) begin ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic scroll(input logic l, input logic r);
    scroll_left = l; scroll_right = r;
    @(negedge clk);
    scroll_left = 1'b0; scroll_right = 1'b0;
  endtask

  task automatic wait_done_fall(output bit ok);
    bit seen;
    seen = 1'b0;
    ok   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mult_done) seen = 1'b1;
      else if (seen) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; go = 1'b0; a = 8'h00; b = 8'h00; scroll_left = 1'b0; scroll_right = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mult_start, busy, valid, negative, win_pos, window, mult_multiplier, mult_multiplicand} !== 37'h0) begin
      n_mis++;
      $display("FAIL reset_outputs: got start=%b busy=%b valid=%b neg=%b pos=%b win=%h mp=%h mc=%h, expected all 0",
               mult_start, busy, valid, negative, win_pos, window, mult_multiplier, mult_multiplicand);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed_scroll;
    bit ok;
    logic [15:0] exp_w [4] = '{16'h0013, 16'h0013, 16'h0013, 16'h0132};
    logic        exp_p [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        sl    [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        sr    [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_go(8'd12, 8'hF5);
    n_cmp++;
    if (mult_multiplicand !== 8'd12 || mult_multiplier !== 8'd11 || busy !== 1'b1 || valid !== 1'b0) begin
      n_mis++;
      $display("FAIL operands_12x-11: got mc=%0d mp=%0d busy=%b valid=%b, expected 12 11 1 0",
               mult_multiplicand, mult_multiplier, busy, valid);
    end
    wait_valid(ok);
    n_cmp++;
    if (!ok || window !== 16'h0132 || negative !== 1'b1 || win_pos !== 1'b0) begin
      n_mis++;
      $display("FAIL result_12x-11: got ok=%b win=%h neg=%b pos=%b, expected 0132 1 0", ok, window, negative, win_pos);
    end
    for (int i = 0; i < 4; i++) begin
      scroll(sl[i], sr[i]);
      n_cmp++;
      if (window !== exp_w[i] || win_pos !== exp_p[i] || valid !== 1'b1) begin
        n_mis++;
        $display("FAIL scroll_step%0d: got win=%h pos=%b valid=%b, expected %h %b 1", i, window, win_pos, valid, exp_w[i], exp_p[i]);
      end
    end
  endtask

  task automatic test_corners;
    bit ok;
    logic [7:0]  ca [3] = '{8'h80, 8'h00, 8'hFF};
    logic [7:0]  cb [3] = '{8'h80, 8'hFB, 8'h01};
    logic [15:0] cw [3] = '{16'h6384, 16'h0000, 16'h0001};
    logic        cn [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      do_go(ca[i], cb[i]);
      wait_valid(ok);
      n_cmp++;
      if (!ok || window !== cw[i] || negative !== cn[i]) begin
        n_mis++;
        $display("FAIL corner%0d: got ok=%b win=%h neg=%b, expected %h %b", i, ok, window, negative, cw[i], cn[i]);
      end
      if (i == 0) begin
        scroll(1'b1, 1'b0);
        n_cmp++;
        if (window !== 16'h1638 || win_pos !== 1'b1) begin
          n_mis++;
          $display("FAIL corner_scroll: got win=%h pos=%b, expected 1638 1", window, win_pos);
        end
      end
    end
  endtask

  task automatic test_go_ignored_latency;
    bit ok;
    int rises0;
    rises0 = start_rises;
    do_go(8'd7, 8'd9);
    a = 8'd100; b = 8'd100; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_done_fall(ok);
    n_cmp++;
    if (!ok) begin
      n_mis++;
      $display("FAIL done_fall_timeout: got no mult_done fall, expected one");
    end
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      #1;
      go = (k == 5);
      if (k == 16) begin
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
          n_mis++;
          $display("FAIL latency_early: got valid=%b busy=%b at edge 16, expected 0 1", valid, busy);
        end
      end
      if (k == 17) begin
        n_cmp++;
        if (valid !== 1'b1) begin
          n_mis++;
          $display("FAIL latency_edge17: got valid=%b, expected 1", valid);
        end
      end
    end
    go = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (window !== 16'h0063 || negative !== 1'b0 || start_rises - rises0 !== 1) begin
      n_mis++;
      $display("FAIL go_ignored: got win=%h neg=%b rises=%0d, expected 0063 0 1", window, negative, start_rises - rises0);
    end
  endtask

  task automatic test_reset_mid_conv;
    bit ok;
    do_go(8'd99, 8'hB3);
    wait_done_fall(ok);
    @(posedge clk);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if (!ok || {mult_start, busy, valid, negative, win_pos, window, mult_multiplier, mult_multiplicand} !== 37'h0) begin
      n_mis++;
      $display("FAIL reset_mid_conv: got ok=%b start=%b busy=%b valid=%b neg=%b pos=%b win=%h mp=%h mc=%h, expected all 0",
               ok, mult_start, busy, valid, negative, win_pos, window, mult_multiplier, mult_multiplicand);
    end
    do_go(8'd3, 8'd4);
    wait_valid(ok);
    n_cmp++;
    if (!ok || window !== 16'h0012 || negative !== 1'b0) begin
      n_mis++;
      $display("FAIL after_reset_3x4: got ok=%b win=%h neg=%b, expected 0012 0", ok, window, negative);
    end
  endtask

  task automatic test_random;
    bit ok;
    logic [7:0] ra, rb;
    logic l, r;
    int pos_m, p;
    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      p  = ref_prod(ra, rb);
      do_go(ra, rb);
      wait_valid(ok);
      n_cmp++;
      if (!ok || window !== ref_window(p, 0) || negative !== ref_neg(ra, rb) || win_pos !== 1'b0) begin
        n_mis++;
        $display("FAIL rand%0d a=%0d b=%0d: got ok=%b win=%h neg=%b pos=%b, expected %h %b 0",
                 n, $signed(ra), $signed(rb), ok, window, negative, win_pos, ref_window(p, 0), ref_neg(ra, rb));
      end
      pos_m = 0;
      for (int s = 0; s < 4; s++) begin
        l = 1'($urandom);
        r = 1'($urandom);
        if (l && !r && pos_m < 1) pos_m++;
        else if (r && !l && pos_m > 0) pos_m--;
        scroll(l, r);
        n_cmp++;
        if (window !== ref_window(p, pos_m) || win_pos !== 1'(pos_m)) begin
          n_mis++;
          $display("FAIL rand%0d_scroll%0d: got win=%h pos=%b, expected %h %0d", n, s, window, win_pos, ref_window(p, pos_m), pos_m);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed_scroll();
    test_corners();
    test_go_ignored_latency();
    test_reset_mid_conv();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
